dm_port_arbiter: RTL and testbench
==================================

# dm_port_arbiter

Two-requester arbiter for the single-port 256x8 data memory (DM1) behind TopLevel. It lets the CPU core (port 0) and a preload/readback loader (port 1) share the memory, so operands can be written and results collected without hierarchical pokes. Arbitration is round-robin. An optional lock holds ownership for multi-byte bursts, such as loading operands at addresses 1–4 or reading results at 5–8. Read data returns one cycle after grant, matching the memory's synchronous read.

## Interface
Parameters:
- AW, 8, memory address width (256 entries)
- DW, 8, data width

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- Req0 / Req1  in  1  access request, port 0 = core, port 1 = loader
- We0 / We1  in  1  1 = write, 0 = read; valid with ReqN
- Addr0 / Addr1  in  AW  access address
- WData0 / WData1  in  DW  write data
- Lock0 / Lock1  in  1  hold ownership after this access; exists only when the macro is defined
- Gnt0 / Gnt1  out  1  access accepted this cycle; combinational
- RValid0 / RValid1  out  1  read data valid for port N; registered
- RData  out  DW  read data, shared by both ports; qualified by RValidN
- MemAddr  out  AW  memory address
- MemWe  out  1  memory write enable
- MemWData  out  DW  memory write data
- MemRData  in  DW  memory read data, valid the cycle after MemAddr is presented

## Operation
- An access is accepted on the rising edge where ReqN && GntN.
- Requesters must hold Req, We, Addr and WData stable until granted.
- At most one grant per cycle. Gnt0 && Gnt1 is never true.
- Memory mux:
  - MemAddr/MemWData come from the granted port.
  - With no grant, MemAddr holds its last value and MemWe = 0.
  - MemWe = GntN && WeN.
- Round-robin: 1-bit register Last records the most recently granted port.
  - Single requester: granted immediately.
  - Both requesting: grant the port != Last.
  - Last updates only on an accepted access.
- Read return:
  - An accepted read sets RValidN = 1 on the next cycle, with RData = MemRData.
  - RValidN is a 1-cycle pulse; back-to-back reads produce back-to-back pulses.
  - Writes never produce RValid.
- Lock state machine (macro enabled):
  - States: OPEN, OWN0, OWN1.
  - OPEN → OWNn: accepted access from port n with LockN = 1.
  - OWNn → OWNn: accepted access with LockN = 1.
  - OWNn → OPEN: accepted access with LockN = 0, or ReqN = 0 for one cycle (owner idle releases the lock).
  - In OWNn, the other port's Gnt is forced to 0 regardless of Last.
  - On release, Last = n, so the other port wins the next tie.
- Reset:
  - State = OPEN, Last = 1 (port 0 wins the first tie).
  - RValid0 = RValid1 = 0, RData = 0, MemAddr = 0.
  - While Reset = 1: Gnt0 = Gnt1 = 0 and MemWe = 0.
  - Reset mid-burst drops ownership and any pending RValid. No write occurs in the reset cycle.

## Timing
- Grant latency 0 cycles: Gnt is combinational from Req, Last and state.
- Read latency 1 cycle: RValid and RData are registered one cycle after the grant edge.
- Write commits at the grant edge.
- Throughput is one access per cycle. Under continuous contention with no lock, each port gets 50% (alternating).
- Worst-case wait without lock: 1 cycle.
- Worst-case wait with lock: the owner's burst length + 1.
- Read-after-write to the same address from either port, on consecutive cycles, returns the new data (memory write-first at the edge).

## Configuration
- DM_ARB_LOCK_EN defined:
  - Lock0/Lock1 ports exist.
  - OPEN/OWN0/OWN1 FSM is active.
- Not defined:
  - Lock ports are absent.
  - Pure round-robin every cycle; no state beyond Last and the RValid/RData registers.

## Test plan
- Reset, then port 1 writes 0x03, 0xff, 0xff, 0xfb to addresses 1–4 alone → Gnt1 high 4 consecutive cycles, MemWe = 1 each, memory holds those values.
- Port 0 reads address 2 → RValid0 = 1 one cycle later with RData = 0xff; RValid1 stays 0.
- Both ports request reads continuously for 6 cycles right after reset → grants 0,1,0,1,0,1. Each RValidN follows its grant by exactly 1 cycle.
- DM_ARB_LOCK_EN: port 1 writes addresses 5–8 with Lock1 = 1 on the first three writes and 0 on the last, while Req0 is held → Gnt1 4 cycles, Gnt0 on cycle 5.
- Reset asserted in the 2nd cycle of a locked burst and in the cycle after a read grant → no RValid pulse; state OPEN; the next tie goes to port 0.
- Macro undefined, same stimulus as the lock test → grants alternate 1,0,1,0 … with no ownership hold.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// Round-robin arbiter sharing the 256x8 data memory between the core (port 0) and loader (port 1).
// Define DM_ARB_LOCK_EN to add Lock0/Lock1 ports and the OPEN/OWN0/OWN1 burst-ownership FSM.
module dm_port_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Req0,
    input  logic          Req1,
    input  logic          We0,
    input  logic          We1,
    input  logic [AW-1:0] Addr0,
    input  logic [AW-1:0] Addr1,
    input  logic [DW-1:0] WData0,
    input  logic [DW-1:0] WData1,
`ifdef DM_ARB_LOCK_EN
    input  logic          Lock0,
    input  logic          Lock1,
`endif
    output logic          Gnt0,
    output logic          Gnt1,
    output logic          RValid0,
    output logic          RValid1,
    output logic [DW-1:0] RData,
    output logic [AW-1:0] MemAddr,
    output logic          MemWe,
    output logic [DW-1:0] MemWData,
    input  logic [DW-1:0] MemRData
);

`ifdef DM_ARB_LOCK_EN
    typedef enum logic [1:0] {
        OPEN = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } lock_state_e;

    lock_state_e state_q, state_d;
`endif

    logic          last_q, last_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          rr_gnt0, rr_gnt1;
    logic          gnt0, gnt1;

    // last_q = 1 means port 1 was granted most recently, so port 0 wins a tie.
    assign rr_gnt0 = Req0 && (!Req1 || last_q);
    assign rr_gnt1 = Req1 && (!Req0 || !last_q);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!Reset) begin
`ifdef DM_ARB_LOCK_EN
            case (state_q)
                OWN0:    gnt0 = Req0;
                OWN1:    gnt1 = Req1;
                default: begin
                    gnt0 = rr_gnt0;
                    gnt1 = rr_gnt1;
                end
            endcase
`else
            gnt0 = rr_gnt0;
            gnt1 = rr_gnt1;
`endif
        end
    end

    assign Gnt0     = gnt0;
    assign Gnt1     = gnt1;
    assign MemWe    = (gnt0 && We0) || (gnt1 && We1);
    assign MemAddr  = gnt0 ? Addr0 : (gnt1 ? Addr1 : mem_addr_q);
    assign MemWData = gnt1 ? WData1 : WData0;

    // Pending read pulses are suppressed while Reset is high so a reset right after a grant yields no pulse.
    assign RValid0 = rvalid0_q && !Reset;
    assign RValid1 = rvalid1_q && !Reset;
    assign RData   = (RValid0 || RValid1) ? MemRData : '0;

    always_comb begin
        last_d     = last_q;
        rvalid0_d  = gnt0 && !We0;
        rvalid1_d  = gnt1 && !We1;
        mem_addr_d = MemAddr;
        if (gnt0) begin
            last_d = 1'b0;
        end else if (gnt1) begin
            last_d = 1'b1;
        end
    end

`ifdef DM_ARB_LOCK_EN
    // While owning, the owner is the only port that can be granted, so last_q already names it on release.
    always_comb begin
        state_d = state_q;
        case (state_q)
            OPEN: begin
                if (gnt0 && Lock0) begin
                    state_d = OWN0;
                end else if (gnt1 && Lock1) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!Req0 || !Lock0) begin
                    state_d = OPEN;
                end
            end
            OWN1: begin
                if (!Req1 || !Lock1) begin
                    state_d = OPEN;
                end
            end
            default: state_d = OPEN;
        endcase
    end
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            last_q     <= 1'b1;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            mem_addr_q <= '0;
`ifdef DM_ARB_LOCK_EN
            state_q    <= OPEN;
`endif
        end else begin
            last_q     <= last_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            mem_addr_q <= mem_addr_d;
`ifdef DM_ARB_LOCK_EN
            state_q    <= state_d;
`endif
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: directed steps then random traffic against a rule-level model.
// Works with and without DM_ARB_LOCK_EN.
module tb_dm_port_arbiter;

`ifdef DM_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, we0, we1, lock0, lock1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic       clear_mem;
    logic [7:0] tb_mem [256];

    int         n_checks = 0;
    int         n_errors = 0;

    // Reference model state: owner -1 means no lock held.
    int         m_last, m_owner;
    bit         m_pv0, m_pv1;
    logic [7:0] m_pdata, m_hold;
    logic [7:0] m_mem [256];
    bit         exp_g0, exp_g1, exp_we;
    logic       obs_g0, obs_g1, obs_rv0;

    always #5 clk = ~clk;

    dm_port_arbiter #(.AW(8), .DW(8)) dut (
        .Clk      (clk),
        .Reset    (reset),
        .Req0     (req0),
        .Req1     (req1),
        .We0      (we0),
        .We1      (we1),
        .Addr0    (addr0),
        .Addr1    (addr1),
        .WData0   (wdata0),
        .WData1   (wdata1),
`ifdef DM_ARB_LOCK_EN
        .Lock0    (lock0),
        .Lock1    (lock1),
`endif
        .Gnt0     (gnt0),
        .Gnt1     (gnt1),
        .RValid0  (rvalid0),
        .RValid1  (rvalid1),
        .RData    (rdata),
        .MemAddr  (mem_addr),
        .MemWe    (mem_we),
        .MemWData (mem_wdata),
        .MemRData (mem_rdata)
    );

    // Synchronous write-first memory standing in for DM1.
    always @(posedge clk) begin
        if (clear_mem) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= 8'h00;
        end else if (mem_we) begin
            tb_mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem_we ? mem_wdata : tb_mem[mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int port, input logic req, input logic we,
                                 input logic [7:0] addr, input logic [7:0] wdata, input logic lock);
        if (port == 0) begin
            req0 = req; we0 = we; addr0 = addr; wdata0 = wdata; lock0 = lock;
        end else begin
            req1 = req; we1 = we; addr1 = addr; wdata1 = wdata; lock1 = lock;
        end
    endtask

    task automatic predict();
        exp_g0 = 1'b0;
        exp_g1 = 1'b0;
        if (!reset) begin
            if (LOCK_EN && m_owner == 0) exp_g0 = req0;
            else if (LOCK_EN && m_owner == 1) exp_g1 = req1;
            else if (req0 && req1) begin
                if (m_last == 1) exp_g0 = 1'b1;
                else exp_g1 = 1'b1;
            end else begin
                exp_g0 = req0;
                exp_g1 = req1;
            end
        end
        exp_we = (exp_g0 && we0) || (exp_g1 && we1);
    endtask

    task automatic checkOutput(input string tag);
        logic [7:0] ea;
        predict();
        ea = exp_g0 ? addr0 : (exp_g1 ? addr1 : m_hold);
        obs_g0 = gnt0;
        obs_g1 = gnt1;
        obs_rv0 = rvalid0;
        check_eq({tag, ".gnt0"}, gnt0, exp_g0);
        check_eq({tag, ".gnt1"}, gnt1, exp_g1);
        check_eq({tag, ".mem_we"}, mem_we, exp_we);
        if (!reset) check_eq({tag, ".mem_addr"}, mem_addr, ea);
        if (exp_we) check_eq({tag, ".mem_wdata"}, mem_wdata, exp_g0 ? wdata0 : wdata1);
        check_eq({tag, ".rvalid0"}, rvalid0, m_pv0 && !reset);
        check_eq({tag, ".rvalid1"}, rvalid1, m_pv1 && !reset);
        if ((m_pv0 || m_pv1) && !reset) check_eq({tag, ".rdata"}, rdata, m_pdata);
    endtask

    task automatic update_model();
        logic [7:0] a;
        if (reset) begin
            m_last = 1; m_owner = -1; m_pv0 = 0; m_pv1 = 0; m_hold = 8'h00;
            if (clear_mem) for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        end else begin
            m_pv0 = exp_g0 && !we0;
            m_pv1 = exp_g1 && !we1;
            if (exp_g0 || exp_g1) begin
                a = exp_g0 ? addr0 : addr1;
                m_pdata = m_mem[a];
                if (exp_we) m_mem[a] = exp_g0 ? wdata0 : wdata1;
                m_hold = a;
                m_last = exp_g0 ? 0 : 1;
            end
            if (LOCK_EN) begin
                if (m_owner < 0) begin
                    if (exp_g0 && lock0) m_owner = 0;
                    else if (exp_g1 && lock1) m_owner = 1;
                end else if (m_owner == 0) begin
                    if (!req0 || !lock0) m_owner = -1;
                end else if (!req1 || !lock1) begin
                    m_owner = -1;
                end
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic step(input string tag);
        #4;
        checkOutput(tag);
        advance();
    endtask

    initial begin
        logic [7:0] burst_data [4];
        logic [7:0] load_data [4];
        int         p1_idx, cyc, done_cyc, first_g0;

        load_data[0] = 8'h03; load_data[1] = 8'hff; load_data[2] = 8'hff; load_data[3] = 8'hfb;
        burst_data[0] = 8'h11; burst_data[1] = 8'h22; burst_data[2] = 8'h33; burst_data[3] = 8'h44;
        m_last = 1; m_owner = -1; m_pv0 = 0; m_pv1 = 0; m_hold = 8'h00; m_pdata = 8'h00;
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;

        // Reset with both ports requesting writes: no grant, no write.
        reset = 1'b1; clear_mem = 1'b1;
        applyStimulus(0, 1, 1, 8'h10, 8'h55, 0);
        applyStimulus(1, 1, 1, 8'h11, 8'h66, 0);
        step("reset");
        reset = 1'b0; clear_mem = 1'b0;
        applyStimulus(0, 0, 0, 8'h00, 8'h00, 0);
        applyStimulus(1, 0, 0, 8'h00, 8'h00, 0);
        #4;
        checkOutput("post_reset");
        check_eq("post_reset.rdata_zero", rdata, 8'h00);
        check_eq("post_reset.mem_addr_zero", mem_addr, 8'h00);
        advance();

        // Loader writes operands to addresses 1..4.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 1, 8'(i + 1), load_data[i], 0);
            step("load");
            check_eq("load.gnt1", obs_g1, 1'b1);
        end
        applyStimulus(1, 0, 0, 8'h00, 8'h00, 0);
        for (int i = 0; i < 4; i++) check_eq("load.mem_content", tb_mem[i + 1], load_data[i]);

        // Core reads address 2, data returns next cycle.
        applyStimulus(0, 1, 0, 8'h02, 8'h00, 0);
        step("core_read");
        applyStimulus(0, 0, 0, 8'h00, 8'h00, 0);
        #4;
        checkOutput("core_read_ret");
        check_eq("core_read_ret.rdata_ff", rdata, 8'hff);
        advance();

        // Reset then six cycles of continuous contention.
        reset = 1'b1;
        step("reset2");
        reset = 1'b0;
        applyStimulus(0, 1, 0, 8'h01, 8'h00, 0);
        applyStimulus(1, 1, 0, 8'h03, 8'h00, 0);
        for (int i = 0; i < 6; i++) begin
            step("contend");
            check_eq("contend.alternate", obs_g0, (i % 2) == 0);
        end
        applyStimulus(1, 0, 0, 8'h00, 8'h00, 0);
        step("contend_tail");
        step("core_alone");
        applyStimulus(0, 0, 0, 8'h00, 8'h00, 0);
        step("idle");

        // Loader burst to 5..8 with lock while the core keeps requesting.
        applyStimulus(0, 1, 0, 8'h09, 8'h00, 0);
        applyStimulus(1, 1, 1, 8'h05, burst_data[0], 1);
        p1_idx = 0; cyc = 0; done_cyc = 0; first_g0 = 0;
        while (p1_idx < 4 && cyc < 12) begin
            cyc++;
            step("burst");
            if (obs_g0 && first_g0 == 0) first_g0 = cyc;
            if (exp_g1) begin
                p1_idx++;
                if (p1_idx < 4) applyStimulus(1, 1, 1, 8'(5 + p1_idx), burst_data[p1_idx], p1_idx < 3);
                else applyStimulus(1, 0, 0, 8'h00, 8'h00, 0);
            end
        end
        done_cyc = cyc;
        cyc++;
        step("burst_after");
        if (obs_g0 && first_g0 == 0) first_g0 = cyc;
        check_eq("burst.cycles", done_cyc, LOCK_EN ? 4 : 7);
        check_eq("burst.first_gnt0", first_g0, LOCK_EN ? 5 : 2);
        applyStimulus(0, 0, 0, 8'h00, 8'h00, 0);
        step("idle2");

        // Reset in the second cycle of a locked burst.
        applyStimulus(1, 1, 1, 8'h14, 8'haa, 1);
        step("rburst1");
        applyStimulus(1, 1, 1, 8'h15, 8'hbb, 1);
        reset = 1'b1;
        step("rburst_reset");
        reset = 1'b0;
        applyStimulus(0, 1, 0, 8'h01, 8'h00, 0);
        applyStimulus(1, 1, 0, 8'h02, 8'h00, 0);
        step("rburst_tie");
        check_eq("rburst_tie.port0_wins", obs_g0, 1'b1);
        applyStimulus(0, 0, 0, 8'h00, 8'h00, 0);
        step("rburst_tail");
        applyStimulus(1, 0, 0, 8'h00, 8'h00, 0);

        // Reset in the cycle after a read grant drops the pulse.
        applyStimulus(0, 1, 0, 8'h03, 8'h00, 0);
        step("rread_grant");
        applyStimulus(0, 0, 0, 8'h00, 8'h00, 0);
        reset = 1'b1;
        step("rread_reset");
        check_eq("rread_reset.no_pulse", obs_rv0, 1'b0);
        reset = 1'b0;
        step("rread_idle");
        applyStimulus(0, 1, 0, 8'h04, 8'h00, 0);
        applyStimulus(1, 1, 0, 8'h05, 8'h00, 0);
        step("rread_tie");
        check_eq("rread_tie.port0_wins", obs_g0, 1'b1);
        applyStimulus(0, 0, 0, 8'h00, 8'h00, 0);
        applyStimulus(1, 0, 0, 8'h00, 8'h00, 0);
        step("idle3");

        // Random traffic; requests stay stable until the model says they were granted.
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 63) == 0);
            step("random");
            if (!req0 || exp_g0) begin
                applyStimulus(0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                              8'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, 2) != 0);
            end
            if (!req1 || exp_g1) begin
                applyStimulus(1, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                              8'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, 2) != 0);
            end
        end
        reset = 1'b0;
        applyStimulus(0, 0, 0, 8'h00, 8'h00, 0);
        applyStimulus(1, 0, 0, 8'h00, 8'h00, 0);
        step("final");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
